// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit Fibonacci PRBS link.
// The generator and the checker both import this package.
package lfsr_pkg;

   localparam int             LFSR_W    = 8;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'h01;
   // Feedback taps: bits 4, 3, 2 and 0.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } chk_state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
      return {^(r & LFSR_TAPS), r[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/lfsr_checker_hex7seg.sv
// Nibble to active-low seven-segment glyph (bit0 = a ... bit6 = g).
// Letters use the usual A, b, C, d, E, F shapes.
module hex7seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1111111;
      case (nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising receive checker for the 8-bit PRBS stream with a
// saturating error counter shown on two seven-segment digits.
module lfsr_checker
   import lfsr_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [LFSR_W-1:0] in_data,
   input  logic              clr_err,
   output logic              locked,
   output logic              err_pulse,
   output logic [7:0]        err_cnt,
   output logic [6:0]        seg1,
   output logic [6:0]        seg2
);

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

   chk_state_t        state_reg;
   logic [LFSR_W-1:0] prev_reg;
   logic              have_prev_reg;
   logic [3:0]        hit_cnt_reg;
   logic [3:0]        miss_cnt_reg;
   logic              locked_reg;
   logic              err_pulse_reg;
   logic [7:0]        err_cnt_reg;

   logic [LFSR_W-1:0] expect_byte;
   logic              match;
   logic [3:0]        hit_inc;
   logic [3:0]        miss_inc;

   assign expect_byte = lfsr_next(prev_reg);
   // The all-zero state is the LFSR lock-up point, so it never counts as a match.
   assign match    = in_valid && have_prev_reg && (in_data == expect_byte) && (in_data != '0);
   assign hit_inc  = hit_cnt_reg + 4'd1;
   assign miss_inc = miss_cnt_reg + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_HUNT;
         prev_reg      <= '0;
         have_prev_reg <= 1'b0;
         hit_cnt_reg   <= 4'd0;
         miss_cnt_reg  <= 4'd0;
         locked_reg    <= 1'b0;
         err_pulse_reg <= 1'b0;
         err_cnt_reg   <= 8'h00;
      end else begin
         err_pulse_reg <= 1'b0;
         if (clr_err) begin
            err_cnt_reg <= 8'h00;
         end
         if (in_valid) begin
            case (state_reg)
               ST_HUNT: begin
                  prev_reg      <= in_data;
                  have_prev_reg <= 1'b1;
                  if (have_prev_reg) begin
                     if (match) begin
                        if (hit_inc == LOCK_N) begin
                           state_reg    <= ST_LOCKED;
                           locked_reg   <= 1'b1;
                           hit_cnt_reg  <= 4'd0;
                           miss_cnt_reg <= 4'd0;
                        end else begin
                           hit_cnt_reg <= hit_inc;
                        end
                     end else begin
                        hit_cnt_reg <= 4'd0;
                     end
                  end
               end
               ST_LOCKED: begin
                  // Flywheel on the prediction so a single bad byte costs one error.
                  prev_reg <= expect_byte;
                  if (match) begin
                     miss_cnt_reg <= 4'd0;
                  end else begin
                     err_pulse_reg <= 1'b1;
                     if (!clr_err && err_cnt_reg != 8'hFF) begin
                        err_cnt_reg <= err_cnt_reg + 8'd1;
                     end
                     if (miss_inc == LOSS_N) begin
                        state_reg    <= ST_HUNT;
                        locked_reg   <= 1'b0;
                        prev_reg     <= in_data;
                        hit_cnt_reg  <= 4'd0;
                        miss_cnt_reg <= 4'd0;
                     end else begin
                        miss_cnt_reg <= miss_inc;
                     end
                  end
               end
               default: begin
                  state_reg  <= ST_HUNT;
                  locked_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign locked    = locked_reg;
   assign err_pulse = err_pulse_reg;
   assign err_cnt   = err_cnt_reg;

   hex7seg u_seg_hi (
      .nibble (err_cnt_reg[7:4]),
      .seg    (seg1)
   );

   hex7seg u_seg_lo (
      .nibble (err_cnt_reg[3:0]),
      .seg    (seg2)
   );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a vector table for the lock-up and a
// single-error case, then hand-written multi-cycle sequences.
module tb_lfsr_checker;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       clr_err;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_cnt;
   logic [6:0] seg1;
   logic [6:0] seg2;

   int checks = 0;
   int errors = 0;

   lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_err   (clr_err),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .seg1      (seg1),
      .seg2      (seg2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic       clr;
      logic       e_locked;
      logic       e_pulse;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [7:0] ref_next(input logic [7:0] r);
      return {r[4] ^ r[3] ^ r[2] ^ r[0], r[7:1]};
   endfunction

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g [16];
      g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return g[n];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic v, input logic [7:0] d, input logic c);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      clr_err  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clr_err  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [7:0] gen;
   logic [7:0] model_cnt;
   logic       flag;
   logic       flag2;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clr_err  = 1'b0;

      //            v    d      clr   lock  pulse cnt
      vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[5]  = '{1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[6]  = '{1'b1, 8'hC5, 1'b0, 1'b1, 1'b1, 8'h01};
      vecs[7]  = '{1'b1, 8'hE2, 1'b0, 1'b1, 1'b0, 8'h01};
      vecs[8]  = '{1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h01};
      vecs[9]  = '{1'b1, 8'h71, 1'b0, 1'b1, 1'b0, 8'h01};
      vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};

      repeat (2) @(negedge clk);
      check("reset_locked", 32'(locked), 32'd0);
      check("reset_pulse", 32'(err_pulse), 32'd0);
      check("reset_cnt", 32'(err_cnt), 32'h00);
      check("reset_seg1", 32'(seg1), 32'h40);
      check("reset_seg2", 32'(seg2), 32'h40);
      rst_n = 1'b1;

      // Lock-up on a clean stream, then one corrupted byte.
      for (int i = 0; i < 11; i++) begin
         apply(vecs[i].v, vecs[i].d, vecs[i].clr);
         check($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].e_locked));
         check($sformatf("vec%0d_pulse", i), 32'(err_pulse), 32'(vecs[i].e_pulse));
         check($sformatf("vec%0d_cnt", i), 32'(err_cnt), 32'(vecs[i].e_cnt));
         check($sformatf("vec%0d_seg1", i), 32'(seg1), 32'(glyph(vecs[i].e_cnt[7:4])));
         check($sformatf("vec%0d_seg2", i), 32'(seg2), 32'(glyph(vecs[i].e_cnt[3:0])));
      end

      // Three consecutive bad bytes drop lock on the third.
      gen = ref_next(8'h71);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, gen ^ 8'h01, 1'b0);
         gen = ref_next(gen);
         check($sformatf("loss%0d_pulse", i), 32'(err_pulse), 32'd1);
         check($sformatf("loss%0d_cnt", i), 32'(err_cnt), 32'(i + 1));
         check($sformatf("loss%0d_locked", i), 32'(locked), (i < 2) ? 32'd1 : 32'd0);
      end
      // Relock: first clean byte reseeds, next four matches lock.
      for (int k = 1; k <= 5; k++) begin
         apply(1'b1, gen, 1'b0);
         gen = ref_next(gen);
         check($sformatf("relock%0d_locked", k), 32'(locked), (k == 5) ? 32'd1 : 32'd0);
         check($sformatf("relock%0d_pulse", k), 32'(err_pulse), 32'd0);
      end
      check("relock_cnt", 32'(err_cnt), 32'h03);

      // "2 bad, 1 good" keeps lock while the counter saturates.
      model_cnt = 8'h03;
      flag = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (i % 3 != 2) begin
            apply(1'b1, gen ^ 8'h01, 1'b0);
            if (model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
         end else begin
            apply(1'b1, gen, 1'b0);
         end
         gen = ref_next(gen);
         if (!locked) flag = 1'b1;
      end
      check("sat_lock_kept", 32'(flag), 32'd0);
      check("sat_cnt", 32'(err_cnt), 32'(model_cnt));
      check("sat_seg1", 32'(seg1), 32'h0E);
      check("sat_seg2", 32'(seg2), 32'h0E);

      apply(1'b0, 8'h00, 1'b1);
      check("clr_cnt", 32'(err_cnt), 32'h00);
      apply(1'b1, gen ^ 8'h01, 1'b0);
      gen = ref_next(gen);
      check("post_clr_err_cnt", 32'(err_cnt), 32'h01);
      // The last two bytes were bad, so this one must be good to hold lock.
      apply(1'b1, gen, 1'b0);
      gen = ref_next(gen);
      apply(1'b1, gen ^ 8'h01, 1'b1);
      gen = ref_next(gen);
      check("clr_coinc_cnt", 32'(err_cnt), 32'h00);
      check("clr_coinc_pulse", 32'(err_pulse), 32'd1);
      check("clr_coinc_locked", 32'(locked), 32'd1);

      // Constant zero never locks.
      do_reset();
      flag = 1'b0;
      for (int i = 0; i < 100; i++) begin
         apply(1'b1, 8'h00, 1'b0);
         if (locked) flag = 1'b1;
      end
      check("zero_never_locked", 32'(flag), 32'd0);
      check("zero_cnt", 32'(err_cnt), 32'h00);

      // Clean stream with in_valid every other cycle, 1000 bytes.
      do_reset();
      gen = 8'h01;
      flag = 1'b0;
      flag2 = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
         apply(1'b1, gen, 1'b0);
         gen = ref_next(gen);
         if (k == 4) check("gap_lock_k4", 32'(locked), 32'd0);
         if (k == 5) check("gap_lock_k5", 32'(locked), 32'd1);
         if (err_pulse) flag = 1'b1;
         apply(1'b0, 8'hA5, 1'b0);
         if (k > 5 && !locked) flag2 = 1'b1;
      end
      check("gap_no_pulse", 32'(flag), 32'd0);
      check("gap_lock_held", 32'(flag2), 32'd0);
      check("gap_cnt", 32'(err_cnt), 32'h00);
      check("gap_seg1", 32'(seg1), 32'h40);
      check("gap_seg2", 32'(seg2), 32'h40);

      // Five isolated errors, then asynchronous reset between clock edges.
      for (int j = 0; j < 5; j++) begin
         apply(1'b1, gen ^ 8'h01, 1'b0);
         gen = ref_next(gen);
         apply(1'b1, gen, 1'b0);
         gen = ref_next(gen);
      end
      check("pre_rst_cnt", 32'(err_cnt), 32'h05);
      check("pre_rst_seg2", 32'(seg2), 32'h12);
      check("pre_rst_locked", 32'(locked), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_locked", 32'(locked), 32'd0);
      check("async_rst_cnt", 32'(err_cnt), 32'h00);
      check("async_rst_seg2", 32'(seg2), 32'h40);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
